// File: rtl/csi_rx_capture_ctrl.sv
// csi_rx_capture_ctrl: frame-capture sequencer that gates CSI-2 payload words to a capture sink.
// Define CSI_CAPTURE_LINE_CHECK_EN to build the per-line word-count checker driving err_len.
module csi_rx_capture_ctrl #(
    parameter int MAX_LINES = 1080,
    parameter int EXP_WORDS = 480,
    parameter int LINE_W    = 12,
    parameter int WORD_W    = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              continuous,
    input  logic              stop,
    input  logic              vsync,
    input  logic              in_frame,
    input  logic              in_line,
    input  logic [31:0]       payload_data,
    input  logic              payload_enable,
    output logic [31:0]       cap_data,
    output logic              cap_valid,
    output logic              cap_sof,
    output logic              cap_eol,
    output logic              busy,
    output logic              done,
    output logic [LINE_W-1:0] line_count,
    output logic [WORD_W-1:0] word_count,
    output logic [15:0]       frame_count,
    output logic              err_overrun,
    output logic              err_len
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [LINE_W-1:0] LINE_SAT    = '1;
    localparam logic [WORD_W-1:0] WORD_SAT    = '1;
    localparam logic [LINE_W-1:0] LINE_ONE    = LINE_W'(1);
    localparam logic [WORD_W-1:0] WORD_ONE    = WORD_W'(1);
    localparam logic [LINE_W:0]   MAX_LINES_X = (LINE_W + 1)'(MAX_LINES);
    localparam logic [WORD_W-1:0] EXP_WORDS_X = WORD_W'(EXP_WORDS);

    state_t          state;
    logic            in_frame_q;
    logic            in_line_q;
    logic            continuous_q;
    logic            stop_pending;
    logic            sof_pending;
    logic            ovr_gate;
    logic            word_clear_pending;

    logic            capturing;
    logic            gate;
    logic            line_end;
    logic            frame_end;
    logic            start_capture;
    logic [LINE_W:0] line_inc;
    logic            line_hits_max;

    always_comb begin
        capturing     = (state == ST_CAPTURE);
        gate          = capturing & payload_enable & ~ovr_gate;
        line_end      = capturing & in_line_q & ~in_line;
        frame_end     = capturing & in_frame_q & ~in_frame;
        start_capture = (state == ST_ARMED) & vsync & ~stop;
        line_inc      = {1'b0, line_count} + {{LINE_W{1'b0}}, 1'b1};
        line_hits_max = (line_inc == MAX_LINES_X);
    end

    always_ff @(posedge clock) begin
        // NOTE: cap_data is reset too, so every output reads zero the cycle after reset.
        if (reset) begin
            state              <= ST_IDLE;
            in_frame_q         <= 1'b0;
            in_line_q          <= 1'b0;
            continuous_q       <= 1'b0;
            stop_pending       <= 1'b0;
            sof_pending        <= 1'b0;
            ovr_gate           <= 1'b0;
            word_clear_pending <= 1'b0;
            cap_data           <= '0;
            cap_valid          <= 1'b0;
            cap_sof            <= 1'b0;
            cap_eol            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            line_count         <= '0;
            word_count         <= '0;
            frame_count        <= '0;
            err_overrun        <= 1'b0;
        end else begin
            in_frame_q <= in_frame;
            in_line_q  <= in_line;
            cap_data   <= payload_data;
            cap_valid  <= gate;
            cap_sof    <= gate & sof_pending;
            cap_eol    <= line_end;

            // word_count keeps the finished line's length until the next line's first word
            if (gate) begin
                sof_pending <= 1'b0;
                if (word_clear_pending) begin
                    word_count         <= WORD_ONE;
                    word_clear_pending <= 1'b0;
                end else if (word_count != WORD_SAT) begin
                    word_count <= word_count + WORD_ONE;
                end
            end

            if (line_end) begin
                word_clear_pending <= 1'b1;
                if (!ovr_gate) begin
                    if (line_count != LINE_SAT)
                        line_count <= line_count + LINE_ONE;
                    if (line_hits_max) begin
                        ovr_gate    <= 1'b1;
                        err_overrun <= 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (arm && !stop) begin
                        state        <= ST_ARMED;
                        continuous_q <= continuous;
                        busy         <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (vsync) begin
                        state              <= ST_CAPTURE;
                        line_count         <= '0;
                        word_count         <= '0;
                        word_clear_pending <= 1'b0;
                        sof_pending        <= 1'b1;
                        ovr_gate           <= 1'b0;
                        err_overrun        <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (stop)
                        stop_pending <= 1'b1;
                    // a line ending in this same cycle was already counted above
                    if (frame_end) begin
                        frame_count  <= frame_count + 16'd1;
                        stop_pending <= 1'b0;
                        if (continuous_q && !stop_pending && !stop) begin
                            state <= ST_ARMED;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (arm && !stop) begin
                        state        <= ST_ARMED;
                        continuous_q <= continuous;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CSI_CAPTURE_LINE_CHECK_EN
    logic [WORD_W-1:0] final_words;
    logic              err_len_q;

    // an empty line still shows the previous line's count, so treat it as zero
    assign final_words = word_clear_pending ? '0 : word_count;

    always_ff @(posedge clock) begin
        if (reset)
            err_len_q <= 1'b0;
        else if (start_capture)
            err_len_q <= 1'b0;
        else if (line_end && !ovr_gate && (final_words != EXP_WORDS_X))
            err_len_q <= 1'b1;
    end

    assign err_len = err_len_q;
`else
    logic [WORD_W-1:0] unused_exp_words;

    assign unused_exp_words = EXP_WORDS_X;
    assign err_len          = 1'b0;
`endif

endmodule

// File: tb/tb_csi_rx_capture_ctrl.sv
// tb_csi_rx_capture_ctrl: randomized frames checked against a line/word-level capture model.
// Two DUT copies share stimulus; the second uses MAX_LINES=2 to exercise the overrun gate.
module tb_csi_rx_capture_ctrl;

    localparam int EXP_WORDS = 480;
    localparam int MAX_MAIN  = 1080;
    localparam int MAX_SMALL = 2;
`ifdef CSI_CAPTURE_LINE_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
    } cap_t;

    typedef enum int {P_NONE, P_STOP, P_ARM} pulse_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic        vsync = 1'b0;
    logic        in_frame = 1'b0;
    logic        in_line = 1'b0;
    logic [31:0] payload_data = '0;
    logic        payload_enable = 1'b0;

    logic [31:0] cap_data,    s_cap_data;
    logic        cap_valid,   s_cap_valid;
    logic        cap_sof,     s_cap_sof;
    logic        cap_eol,     s_cap_eol;
    logic        busy,        s_busy;
    logic        done,        s_done;
    logic [11:0] line_count,  s_line_count;
    logic [13:0] word_count,  s_word_count;
    logic [15:0] frame_count, s_frame_count;
    logic        err_overrun, s_err_overrun;
    logic        err_len,     s_err_len;

    csi_rx_capture_ctrl dut (
        .clock(clock), .reset(reset), .arm(arm), .continuous(continuous), .stop(stop),
        .vsync(vsync), .in_frame(in_frame), .in_line(in_line), .payload_data(payload_data),
        .payload_enable(payload_enable), .cap_data(cap_data), .cap_valid(cap_valid),
        .cap_sof(cap_sof), .cap_eol(cap_eol), .busy(busy), .done(done),
        .line_count(line_count), .word_count(word_count), .frame_count(frame_count),
        .err_overrun(err_overrun), .err_len(err_len)
    );

    csi_rx_capture_ctrl #(.MAX_LINES(MAX_SMALL)) dut_small (
        .clock(clock), .reset(reset), .arm(arm), .continuous(continuous), .stop(stop),
        .vsync(vsync), .in_frame(in_frame), .in_line(in_line), .payload_data(payload_data),
        .payload_enable(payload_enable), .cap_data(s_cap_data), .cap_valid(s_cap_valid),
        .cap_sof(s_cap_sof), .cap_eol(s_cap_eol), .busy(s_busy), .done(s_done),
        .line_count(s_line_count), .word_count(s_word_count), .frame_count(s_frame_count),
        .err_overrun(s_err_overrun), .err_len(s_err_len)
    );

    always #5 clock = ~clock;

    // Monitor: sample outputs on the falling edge, away from the active edge.
    cap_t cap_q[$];
    cap_t cap2_q[$];
    int   eol_cnt = 0;

    always @(negedge clock) begin
        if (cap_valid)   cap_q.push_back({cap_data, cap_sof});
        if (s_cap_valid) cap2_q.push_back({s_cap_data, s_cap_sof});
        if (cap_eol)     eol_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Frame description and reference model state.
    int          line_words[8];
    int          n_lines;
    logic [31:0] frame_data[$];
    int          frame_line[$];
    cap_t        exp_q[$];
    int          m_line_count = 0;
    int          m_word_count = 0;
    int          m_frame_count = 0;
    bit          m_err_len = 1'b0;
    bit          m_err_ovr = 1'b0;
    int          m_eol = 0;
    int          base, base2, eol_base, errs;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mark();
        base     = cap_q.size();
        base2    = cap2_q.size();
        eol_base = eol_cnt;
    endtask

    task automatic pulse_arm(input logic cont);
        continuous = cont;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        continuous = 1'b0;
    endtask

    // Drive one frame: optional vsync, optional arm/stop pulse mid line 0, optional
    // simultaneous fall of in_line and in_frame on the last line.
    task automatic send_frame(input bit do_vsync, input pulse_t pulse, input bit same_fall);
        frame_data.delete();
        frame_line.delete();
        in_frame = 1'b1;
        vsync = do_vsync;
        tick();
        vsync = 1'b0;
        tick();
        tick();
        for (int l = 0; l < n_lines; l++) begin
            in_line = 1'b1;
            tick();
            for (int w = 0; w < line_words[l]; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    payload_enable = 1'b0;
                    tick();
                end
                payload_enable = 1'b1;
                payload_data = $urandom;
                frame_data.push_back(payload_data);
                frame_line.push_back(l);
                if (l == 0 && w == line_words[0] / 2) begin
                    stop = (pulse == P_STOP);
                    arm  = (pulse == P_ARM);
                end
                tick();
                stop = 1'b0;
                arm  = 1'b0;
            end
            payload_enable = 1'b0;
            tick();
            in_line = 1'b0;
            if (same_fall && l == n_lines - 1) in_frame = 1'b0;
            tick();
            tick();
            tick();
        end
        in_frame = 1'b0;
        repeat (4) tick();
    endtask

    function automatic void build_expected(input int max_l, input bit captured);
        exp_q.delete();
        if (captured)
            foreach (frame_data[i])
                if (frame_line[i] < max_l) exp_q.push_back({frame_data[i], exp_q.size() == 0});
    endfunction

    // Expected effect of the frame just sent on a capture sink limited to max_l lines.
    function automatic void model_frame(input int max_l, input bit captured);
        int kept;
        build_expected(max_l, captured);
        m_eol = 0;
        if (captured) begin
            kept = (n_lines < max_l) ? n_lines : max_l;
            m_eol = n_lines;
            m_line_count = kept;
            m_word_count = line_words[kept - 1];
            m_err_ovr = (n_lines >= max_l);
            m_err_len = 1'b0;
            for (int i = 0; i < kept; i++)
                if (line_words[i] != EXP_WORDS) m_err_len = LEN_CHECK;
            m_frame_count = (m_frame_count + 1) % 65536;
        end
    endfunction

    function automatic int queue_diff(input bit second, input int start);
        int   n;
        int   bad;
        cap_t act;
        bad = 0;
        n = (second ? cap2_q.size() : cap_q.size()) - start;
        if (n != exp_q.size()) bad++;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            act = second ? cap2_q[start + i] : cap_q[start + i];
            if (act !== exp_q[i]) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if ({cap_data, cap_valid, cap_sof, cap_eol, busy, done, line_count, word_count,
                         frame_count, err_overrun, err_len} !== '0) begin
            n_fail++; $display("FAIL reset.outputs: got busy=%0b done=%0b fc=%0d lc=%0d wc=%0d valid=%0b, want all 0",
                               busy, done, frame_count, line_count, word_count, cap_valid);
        end
        reset = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset.idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_single_frame();
        pulse_arm(1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single.armed_busy: got %0b want 1", busy); end
        n_lines = 3;
        for (int i = 0; i < 3; i++) line_words[i] = EXP_WORDS;
        mark();
        send_frame(1'b1, P_NONE, 1'b0);
        model_frame(MAX_MAIN, 1'b1);
        errs = queue_diff(1'b0, base);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL single.words: %0d mismatches, got %0d words want %0d", errs, cap_q.size() - base, exp_q.size()); end
        n_checks++; if (eol_cnt - eol_base !== m_eol) begin n_fail++; $display("FAIL single.eol: got %0d want %0d", eol_cnt - eol_base, m_eol); end
        n_checks++; if (line_count !== 12'(m_line_count)) begin n_fail++; $display("FAIL single.line_count: got %0d want %0d", line_count, m_line_count); end
        n_checks++; if (word_count !== 14'(m_word_count)) begin n_fail++; $display("FAIL single.word_count: got %0d want %0d", word_count, m_word_count); end
        n_checks++; if (frame_count !== 16'(m_frame_count)) begin n_fail++; $display("FAIL single.frame_count: got %0d want %0d", frame_count, m_frame_count); end
        n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL single.done_busy: got %b want 10", {done, busy}); end
        n_checks++; if ({err_overrun, err_len} !== {m_err_ovr, m_err_len}) begin n_fail++; $display("FAIL single.errs: got %b want %b", {err_overrun, err_len}, {m_err_ovr, m_err_len}); end
    endtask

    task automatic test_continuous();
        pulse_arm(1'b1);
        n_lines = 2;
        line_words[0] = EXP_WORDS;
        line_words[1] = EXP_WORDS;
        mark();
        send_frame(1'b1, P_NONE, 1'b0);
        model_frame(MAX_MAIN, 1'b1);
        errs = queue_diff(1'b0, base);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL cont.words_a: %0d mismatches", errs); end
        n_checks++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL cont.rearmed: got done,busy=%b want 01", {done, busy}); end
        mark();
        send_frame(1'b1, P_STOP, 1'b0);
        model_frame(MAX_MAIN, 1'b1);
        errs = queue_diff(1'b0, base);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL cont.words_b: %0d mismatches", errs); end
        n_checks++; if (frame_count !== 16'(m_frame_count)) begin n_fail++; $display("FAIL cont.frame_count: got %0d want %0d", frame_count, m_frame_count); end
        n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL cont.stopped: got done,busy=%b want 10", {done, busy}); end
        n_lines = 1;
        line_words[0] = 10;
        mark();
        send_frame(1'b1, P_NONE, 1'b0);
        model_frame(MAX_MAIN, 1'b0);
        n_checks++; if (cap_q.size() - base !== 0) begin n_fail++; $display("FAIL cont.third_gated: got %0d words want 0", cap_q.size() - base); end
        n_checks++; if (frame_count !== 16'(m_frame_count)) begin n_fail++; $display("FAIL cont.third_count: got %0d want %0d", frame_count, m_frame_count); end
        n_checks++; if (line_count !== 12'(m_line_count)) begin n_fail++; $display("FAIL cont.held_lines: got %0d want %0d", line_count, m_line_count); end
    endtask

    task automatic test_partial_frame();
        n_lines = 2;
        line_words[0] = 30;
        line_words[1] = 30;
        mark();
        send_frame(1'b0, P_ARM, 1'b0);
        model_frame(MAX_MAIN, 1'b0);
        n_checks++; if (cap_q.size() - base !== 0) begin n_fail++; $display("FAIL partial.words: got %0d want 0", cap_q.size() - base); end
        n_checks++; if (eol_cnt - eol_base !== 0) begin n_fail++; $display("FAIL partial.eol: got %0d want 0", eol_cnt - eol_base); end
        n_checks++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL partial.armed: got done,busy=%b want 01", {done, busy}); end
        line_words[0] = EXP_WORDS;
        line_words[1] = EXP_WORDS;
        mark();
        send_frame(1'b1, P_NONE, 1'b0);
        model_frame(MAX_MAIN, 1'b1);
        errs = queue_diff(1'b0, base);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL partial.next_words: %0d mismatches", errs); end
        n_checks++; if (frame_count !== 16'(m_frame_count)) begin n_fail++; $display("FAIL partial.frame_count: got %0d want %0d", frame_count, m_frame_count); end
    endtask

    task automatic test_overrun();
        int kept2;
        pulse_arm(1'b0);
        n_lines = 3;
        for (int i = 0; i < 3; i++) line_words[i] = 20;
        mark();
        send_frame(1'b1, P_NONE, 1'b1);
        model_frame(MAX_MAIN, 1'b1);
        n_checks++; if (line_count !== 12'(m_line_count)) begin n_fail++; $display("FAIL ovr.main_lines: got %0d want %0d", line_count, m_line_count); end
        n_checks++; if (eol_cnt - eol_base !== m_eol) begin n_fail++; $display("FAIL ovr.eol: got %0d want %0d", eol_cnt - eol_base, m_eol); end
        n_checks++; if ({done, err_overrun, err_len} !== {1'b1, m_err_ovr, m_err_len}) begin n_fail++; $display("FAIL ovr.main_flags: got %b want %b", {done, err_overrun, err_len}, {1'b1, m_err_ovr, m_err_len}); end
        kept2 = (n_lines < MAX_SMALL) ? n_lines : MAX_SMALL;
        build_expected(MAX_SMALL, 1'b1);
        errs = queue_diff(1'b1, base2);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL ovr.small_words: %0d mismatches, got %0d want %0d", errs, cap2_q.size() - base2, exp_q.size()); end
        n_checks++; if (s_line_count !== 12'(kept2)) begin n_fail++; $display("FAIL ovr.small_lines: got %0d want %0d", s_line_count, kept2); end
        n_checks++; if (s_err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr.small_flag: got %0b want 1", s_err_overrun); end
        n_checks++; if (s_word_count !== 14'(line_words[kept2 - 1])) begin n_fail++; $display("FAIL ovr.small_words_cnt: got %0d want %0d", s_word_count, line_words[kept2 - 1]); end
    endtask

    task automatic test_line_length();
        pulse_arm(1'b0);
        n_lines = 2;
        line_words[0] = EXP_WORDS;
        line_words[1] = EXP_WORDS;
        send_frame(1'b1, P_NONE, 1'b0);
        model_frame(MAX_MAIN, 1'b1);
        n_checks++; if (err_len !== m_err_len) begin n_fail++; $display("FAIL len.clean: got %0b want %0b", err_len, m_err_len); end
        pulse_arm(1'b0);
        n_lines = 3;
        line_words[0] = EXP_WORDS;
        line_words[1] = EXP_WORDS - 1;
        line_words[2] = EXP_WORDS;
        mark();
        send_frame(1'b1, P_NONE, 1'b0);
        model_frame(MAX_MAIN, 1'b1);
        n_checks++; if (err_len !== m_err_len) begin n_fail++; $display("FAIL len.short: got %0b want %0b", err_len, m_err_len); end
        n_checks++; if (word_count !== 14'(m_word_count)) begin n_fail++; $display("FAIL len.word_count: got %0d want %0d", word_count, m_word_count); end
        errs = queue_diff(1'b0, base);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL len.words: %0d mismatches", errs); end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 3; it++) begin
            pulse_arm(1'b0);
            n_lines = $urandom_range(1, 3);
            for (int i = 0; i < n_lines; i++) line_words[i] = $urandom_range(EXP_WORDS - 2, EXP_WORDS + 2);
            mark();
            send_frame(1'b1, P_NONE, $urandom_range(0, 1) == 1);
            model_frame(MAX_MAIN, 1'b1);
            errs = queue_diff(1'b0, base);
            n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL rand%0d.words: %0d mismatches", it, errs); end
            n_checks++; if ({line_count, word_count} !== {12'(m_line_count), 14'(m_word_count)}) begin
                n_fail++; $display("FAIL rand%0d.counts: got lc=%0d wc=%0d want lc=%0d wc=%0d", it, line_count, word_count, m_line_count, m_word_count);
            end
            n_checks++; if ({frame_count, done, err_len} !== {16'(m_frame_count), 1'b1, m_err_len}) begin
                n_fail++; $display("FAIL rand%0d.status: got fc=%0d done=%0b len=%0b want fc=%0d done=1 len=%0b", it, frame_count, done, err_len, m_frame_count, m_err_len);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_arm(1'b0);
        in_frame = 1'b1;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        in_line = 1'b1;
        payload_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            payload_data = $urandom;
            tick();
        end
        reset = 1'b1;
        tick();
        n_checks++; if ({cap_data, cap_valid, cap_sof, cap_eol, busy, done, line_count, word_count,
                         frame_count, err_overrun, err_len} !== '0) begin
            n_fail++; $display("FAIL rstmid.outputs: got busy=%0b valid=%0b fc=%0d wc=%0d, want all 0", busy, cap_valid, frame_count, word_count);
        end
        reset = 1'b0;
        payload_enable = 1'b0;
        in_line = 1'b0;
        in_frame = 1'b0;
        m_frame_count = 0;
        m_line_count = 0;
        m_word_count = 0;
        tick();
        arm = 1'b1;
        stop = 1'b1;
        tick();
        arm = 1'b0;
        stop = 1'b0;
        tick();
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid.arm_stop: got done,busy=%b want 00", {done, busy}); end
        n_lines = 1;
        line_words[0] = 8;
        mark();
        send_frame(1'b1, P_NONE, 1'b0);
        model_frame(MAX_MAIN, 1'b0);
        n_checks++; if (cap_q.size() - base !== 0) begin n_fail++; $display("FAIL rstmid.idle_words: got %0d want 0", cap_q.size() - base); end
        n_checks++; if (frame_count !== 16'(m_frame_count)) begin n_fail++; $display("FAIL rstmid.frame_count: got %0d want %0d", frame_count, m_frame_count); end
        pulse_arm(1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid.armed: got %0b want 1", busy); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid.abort: got done,busy=%b want 00", {done, busy}); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous();
        test_partial_frame();
        test_overrun();
        test_line_length();
        test_random_frames();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
